muldiv_sequencer: RTL and testbench

- Multi-cycle controller for the HI/LO arithmetic path beside the single-cycle ALU in the Harvard MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issues from decode and runs an iterative 1-bit-per-cycle shift-add multiply or restoring divide.
- Owns the HI/LO registers.
- Drives a stall to the pipeline while a result is pending and an instruction needs HI/LO or the unit.

---
 rtl/muldiv_sequencer.sv | 150 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// HI/LO multiply/divide unit: 1-bit-per-cycle shift-add multiply / restoring divide, result WIDTH+1 cycles after issue.
// Starts outside IDLE are ignored; stall asks decode to hold MFHI/MFLO or a new issue while busy.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_req,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t               state_q;
    logic [WIDTH-1:0]     hi_q, lo_q, opnd_q, araw_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 busy_q, done_q, is_div_q, neg_q, sa_q, div0_q;

    logic                 sign_a, sign_b;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum, div_t;
    logic [WIDTH-1:0]     div_diff, rem_d;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   mul_d, div_d, prod_fix;
    logic [WIDTH-1:0]     res_hi, res_lo;

    assign sign_a = op[0] & a[WIDTH-1];
    assign sign_b = op[0] & b[WIDTH-1];
    assign mag_a  = sign_a ? -a : a;
    assign mag_b  = sign_b ? -b : b;

    // Multiply: acc holds {partial sum, remaining multiplier bits}, multiplier consumed LSB first.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_d   = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc holds {partial remainder, dividend bits shifting into quotient}.
    assign div_t    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge   = (div_t >= {1'b0, opnd_q});
    assign div_diff = div_t[WIDTH-1:0] - opnd_q;
    assign rem_d    = div_ge ? div_diff : div_t[WIDTH-1:0];
    assign div_d    = {rem_d, acc_q[WIDTH-2:0], div_ge};

    assign prod_fix = neg_q ? -acc_q : acc_q;

    always_comb begin
        res_hi = prod_fix[2*WIDTH-1:WIDTH];
        res_lo = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            if (div0_q) begin
                res_hi = araw_q;
                res_lo = '1;
            end else begin
                res_lo = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                res_hi = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            araw_q   <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !flush) begin
                        case (op)
                            OP_MTHI: hi_q <= a;
                            OP_MTLO: lo_q <= a;
                            OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: begin
                                state_q  <= RUN;
                                busy_q   <= 1'b1;
                                cnt_q    <= '0;
                                acc_q    <= {{WIDTH{1'b0}}, mag_a};
                                opnd_q   <= mag_b;
                                araw_q   <= a;
                                is_div_q <= op[1];
                                neg_q    <= sign_a ^ sign_b;
                                sa_q     <= sign_a;
                                div0_q   <= (b == '0);
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (flush) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= is_div_q ? div_d : mul_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST) state_q <= FIX;
                    end
                end
                FIX: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (!flush) begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign stall = busy_q & (rd_req | start);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed corner cases plus random ops against an arithmetic HI/LO model.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, rd_req, flush;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        busy, done, stall;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi, m_lo;

    muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .rd_req(rd_req), .flush(flush), .hi(hi), .lo(lo),
        .busy(busy), .done(done), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: what HI/LO hold after an accepted op, from plain 64-bit arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: begin p = {32'd0, x} * {32'd0, y}; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd1: begin p = sx * sy; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd2, 3'd3: begin
                if (y == 0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = x;
                end else if (o == 3'd2) begin
                    m_lo = x / y; m_hi = x % y;
                end else begin
                    q = sx / sy; r = sx % sy;
                    m_lo = q[31:0]; m_hi = r[31:0];
                end
            end
            3'd4: m_hi = x;
            3'd5: m_lo = x;
            default: ;
        endcase
    endtask

    // Called at a negedge; leaves inputs idle #1 after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom;
        model(o, x, y);
    endtask

    // Waits for completion; inject=1 tries an illegal issue mid-run, which must stall and be dropped.
    task automatic wait_done(input string tag, input bit inject);
        int n, dn;
        n = 0; dn = 0;
        @(negedge clk);
        check({tag, "_done_clr"}, done, 0);
        while (busy && n < 100) begin
            n++;
            if (n == 3) begin
                rd_req = 1'b1; #1;
                check({tag, "_stall_rd"}, stall, 1);
                rd_req = 1'b0; #1;
                check({tag, "_stall_norq"}, stall, 0);
            end
            if (inject && n == 5) begin
                start = 1'b1; op = 3'd0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; rd_req = 1'b1; #1;
                check({tag, "_stall_inj"}, stall, 1);
                @(posedge clk); #1;
                start = 1'b0; rd_req = 1'b0;
            end
            @(negedge clk);
            if (done) dn++;
        end
        check({tag, "_busy_cyc"}, n, 33);
        check({tag, "_done_cnt"}, dn, 1);
        check({tag, "_hi"}, hi, m_hi);
        check({tag, "_lo"}, lo, m_lo);
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        issue(o, x, y);
        wait_done(tag, 1'b0);
    endtask

    initial begin
        int dn;
        logic [31:0] old_hi, old_lo;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        rst_n = 1'b0; start = 1'b0; rd_req = 1'b1; flush = 1'b0; op = 3'd0; a = '0; b = '0;
        m_hi = '0; m_lo = '0;
        #12;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_stall_idle", stall, 0);
        rst_n = 1'b1; rd_req = 1'b0;
        @(negedge clk);

        run("multu_max", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max_hi_k", hi, 32'hFFFF_FFFE);
        check("multu_max_lo_k", lo, 32'h0000_0001);
        run("mult_neg", 3'd1, 32'hFFFF_FFFD, 32'd7);
        check("mult_neg_lo_k", lo, 32'hFFFF_FFEB);
        run("mult_min", 3'd1, 32'h8000_0000, 32'h8000_0000);
        check("mult_min_hi_k", hi, 32'h4000_0000);
        run("divu", 3'd2, 32'd100, 32'd7);
        check("divu_lo_k", lo, 32'd14);
        run("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2);
        check("div_neg_lo_k", lo, 32'hFFFF_FFFD);
        check("div_neg_hi_k", hi, 32'hFFFF_FFFF);
        run("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_lo_k", lo, 32'h8000_0000);
        run("divu_zero", 3'd2, 32'h1234, 32'd0);
        check("divu_zero_hi_k", hi, 32'h1234);
        run("div_zero_neg", 3'd3, 32'hFFFF_FF00, 32'd0);

        issue(3'd2, 32'd1000, 32'd33);
        wait_done("inject", 1'b1);

        // Flush after 10 cycles of RUN: no result, no done.
        old_hi = hi; old_lo = lo;
        issue(3'd0, 32'h1357_9BDF, 32'h2468_ACE0);
        m_hi = old_hi; m_lo = old_lo;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy", busy, 0);
        dn = 0;
        repeat (40) begin @(negedge clk); if (done) dn++; end
        check("flush_done", dn, 0);
        check("flush_hi", hi, old_hi);
        check("flush_lo", lo, old_lo);

        issue(3'd4, 32'hDEAD_BEEF, 32'd0);
        check("mthi_hi", hi, 32'hDEAD_BEEF);
        check("mthi_busy", busy, 0);
        @(negedge clk);
        issue(3'd5, 32'h1234_5678, 32'd0);
        check("mtlo_lo", lo, 32'h1234_5678);
        check("mtlo_hi", hi, 32'hDEAD_BEEF);
        check("mtlo_done", done, 0);
        @(negedge clk);

        flush = 1'b1;
        start = 1'b1; op = 3'd4; a = 32'hAAAA_5555;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("idle_flush_hi", hi, 32'hDEAD_BEEF);
        check("idle_flush_busy", busy, 0);
        @(negedge clk);
        start = 1'b1; op = 3'd6; a = 32'h5555_AAAA; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        check("noop_busy", busy, 0);
        check("noop_hi", hi, 32'hDEAD_BEEF);
        check("noop_lo", lo, 32'h1234_5678);
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 5));
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            if (ro >= 3'd4) begin
                issue(ro, ra, rb);
                check($sformatf("rnd%0d_mt_hi", i), hi, m_hi);
                check($sformatf("rnd%0d_mt_lo", i), lo, m_lo);
                @(negedge clk);
            end else begin
                run($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb);
            end
        end

        // Asynchronous reset in the middle of a divide.
        issue(3'd3, 32'h7654_3210, 32'd5);
        repeat (6) @(negedge clk);
        rst_n = 1'b0; #1;
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        check("arst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("arst_after_busy", busy, 0);
        check("arst_after_lo", lo, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
